// File: rtl/intc_ng_pkg.sv
// intc_ng_pkg: register offsets and sizing constants for intc_ng
package intc_ng_pkg;
  localparam logic [1:0] OFF_IE = 2'd0;
  localparam logic [1:0] OFF_IP = 2'd1;
  localparam logic [1:0] OFF_EDGE = 2'd2;
  localparam logic [1:0] OFF_POL = 2'd3;
  localparam int BANK_STRIDE = 4;
  localparam int MAX_INTS = 16;
endpackage

// File: rtl/intc_ng_chan.sv
// intc_ng_chan: one interrupt channel (sync, optional debounce, detect, pending bit)
// INTC_NG_DEBOUNCE_EN inserts a ce-ticked glitch filter after the synchroniser.
module intc_ng_chan #(
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic pin,
  input  logic edge_mode,
  input  logic pol,
  input  logic w1c,
  output logic ip
);
  logic s1, s2, prev, f, act;
`ifdef INTC_NG_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      f <= pin;
      cnt <= '0;
    end else if (s2 == f) cnt <= '0;
    else if (ce) begin
      f <= (cnt == CW'(DEBOUNCE_CNT - 1)) ? s2 : f;
      cnt <= (cnt == CW'(DEBOUNCE_CNT - 1)) ? '0 : cnt + 1'b1;
    end
`else
  localparam int unused_dbc = DEBOUNCE_CNT;
  logic unused_ce;
  assign unused_ce = ce;
  assign f = s2;
`endif
  // prev tracks the filtered level only, so POL/EDGE changes cannot fake an edge
  assign act = edge_mode ? (f != prev && f == pol) : (f == pol);
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= pin;
      s2 <= pin;
      prev <= pin;
      ip <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      prev <= f;
      ip <= act ? 1'b1 : (w1c ? 1'b0 : ip);
    end
endmodule

// File: rtl/intc_ng.sv
// intc_ng: CSR-mapped interrupt controller, NUM_INTS channels in 8-bit banks
// Optional debounce filter in each channel via INTC_NG_DEBOUNCE_EN.
module intc_ng
  import intc_ng_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR = 5'h1c,
  parameter int NUM_INTS = 8,
  parameter logic [15:0] DFL_EDGE = {16{1'b1}},
  parameter logic [15:0] DFL_POL = {16{1'b0}},
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic [4:0]          csr_a,
  input  logic [7:0]          csr_di,
  input  logic                csr_we,
  output logic [7:0]          csr_do,
  input  logic [NUM_INTS-1:0] ints,
  output logic                irq
);
  localparam int NB = (NUM_INTS + 7) / 8;
  localparam logic [15:0] VM = 16'((32'd1 << NUM_INTS) - 1);
  logic [MAX_INTS-1:0] ie, ip, edge_cfg, pol, bm, wd, w1c, sel;
  logic [5:0] rel;
  logic hit, bank;
  logic [1:0] off;
  assign rel = {1'b0, csr_a} - {1'b0, BASE_ADDR};
  assign hit = csr_a >= BASE_ADDR && rel < 6'(BANK_STRIDE * NB);
  assign bank = rel[2];
  assign off = rel[1:0];
  // byte-lane mask of the addressed bank, restricted to implemented channels
  assign bm = hit ? ((16'h00ff << {bank, 3'b000}) & VM) : 16'h0;
  assign wd = {2{csr_di}};
  assign w1c = (csr_we && off == OFF_IP) ? bm : 16'h0;
  assign sel = off == OFF_IE ? ie : off == OFF_IP ? ip : off == OFF_EDGE ? edge_cfg : pol;
  assign csr_do = hit ? (bank ? sel[15:8] : sel[7:0]) : 8'h00;
  always_ff @(posedge clk)
    if (rst) begin
      ie <= '0;
      edge_cfg <= DFL_EDGE & VM;
      pol <= DFL_POL & VM;
      irq <= 1'b0;
    end else begin
      ie <= (csr_we && off == OFF_IE) ? (ie & ~bm) | (wd & bm) : ie;
      edge_cfg <= (csr_we && off == OFF_EDGE) ? (edge_cfg & ~bm) | (wd & bm) : edge_cfg;
      pol <= (csr_we && off == OFF_POL) ? (pol & ~bm) | (wd & bm) : pol;
      irq <= |(ip & ie);
    end
  for (genvar i = 0; i < MAX_INTS; i++) begin : g_ch
    if (i < NUM_INTS) begin : g_on
      intc_ng_chan #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_chan (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .pin(ints[i]),
        .edge_mode(edge_cfg[i]),
        .pol(pol[i]),
        .w1c(w1c[i]),
        .ip(ip[i])
      );
    end else begin : g_off
      assign ip[i] = 1'b0;
    end
  end
endmodule

// File: tb/tb_intc_ng.sv
// tb_intc_ng: directed plus randomized checks of intc_ng against a behavioural model
module tb_intc_ng;
  localparam logic [4:0] BASE = 5'h10;
  localparam int N = 12;
  localparam logic [15:0] VM = 16'h0fff;
  logic clk = 0, rst = 1, ce = 0, csr_we = 0, irq;
  logic [4:0] csr_a = 0;
  logic [7:0] csr_di = 0, csr_do;
  logic [N-1:0] ints = '1;
  int checks = 0, errors = 0;
  intc_ng #(.BASE_ADDR(BASE), .NUM_INTS(N)) dut (
    .clk(clk), .rst(rst), .ce(ce), .csr_a(csr_a), .csr_di(csr_di),
    .csr_we(csr_we), .csr_do(csr_do), .ints(ints), .irq(irq)
  );
  always #5 clk = ~clk;
  // model: pin samples taken at recent edges (sp1 = 2 edges ago, sp2 = 3 edges ago)
  logic [15:0] ie_m, ip_m, ed_m, po_m, sp0, sp1, sp2, act_m, bm_m, wd_m;
  logic irq_m;
  int r_m;
  assign r_m = int'(csr_a) - int'(BASE);
  assign bm_m = (r_m >= 0 && r_m < 8) ? ((16'h00ff << (8 * (r_m / 4))) & VM) : 16'h0;
  assign wd_m = {csr_di, csr_di};
  // active: edge mode = pin just changed and now equals POL; level mode = pin equals POL
  assign act_m = ((ed_m & (sp1 ^ sp2) & ~(sp1 ^ po_m)) | (~ed_m & ~(sp1 ^ po_m))) & VM;
  always @(posedge clk)
    if (rst) begin
      ie_m <= 0; ip_m <= 0; ed_m <= VM; po_m <= 0; irq_m <= 0;
      sp0 <= {4'b0, ints}; sp1 <= {4'b0, ints}; sp2 <= {4'b0, ints};
    end else begin
      irq_m <= |(ip_m & ie_m);
      ip_m <= act_m | (ip_m & ~((csr_we && r_m % 4 == 1) ? bm_m : 16'h0));
      ie_m <= (csr_we && r_m % 4 == 0) ? (ie_m & ~bm_m) | (wd_m & bm_m) : ie_m;
      ed_m <= (csr_we && r_m % 4 == 2) ? (ed_m & ~bm_m) | (wd_m & bm_m) : ed_m;
      po_m <= (csr_we && r_m % 4 == 3) ? (po_m & ~bm_m) | (wd_m & bm_m) : po_m;
      sp0 <= {4'b0, ints}; sp1 <= sp0; sp2 <= sp1;
    end
  function automatic logic [7:0] rd_m(input logic [4:0] a);
    int r;
    logic [15:0] v;
    r = int'(a) - int'(BASE);
    if (r < 0 || r >= 8) return 8'h00;
    v = (r % 4 == 0) ? ie_m : (r % 4 == 1) ? ip_m : (r % 4 == 2) ? ed_m : po_m;
    return v[8 * (r / 4) +: 8];
  endfunction
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic rd(input string tag, input logic [4:0] a, input logic [7:0] exp);
    csr_a = a;
    #1;
    chk(tag, csr_do, exp);
  endtask
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    csr_a = a; csr_di = d; csr_we = 1;
    tick();
    csr_we = 0;
  endtask
  initial begin
    repeat (3) tick();
    rd("rst_ie", BASE, 8'h00);
    rd("rst_ip", BASE + 1, 8'h00);
    rd("rst_edge0", BASE + 2, 8'hff);
    rd("rst_edge1", BASE + 6, 8'h0f);
    rd("rst_pol", BASE + 3, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    rst = 0;
    wr(BASE, 8'h01);
    ints[0] = 0;
    tick(); rd("fall_e1", BASE + 1, 8'h00);
    tick(); rd("fall_e2", BASE + 1, 8'h00);
    tick(); rd("fall_e3", BASE + 1, 8'h01);
    chk("irq_lag", {7'b0, irq}, 8'h00);
    tick(); chk("irq_set", {7'b0, irq}, 8'h01);
    wr(BASE + 1, 8'h01);
    rd("w1c_ip", BASE + 1, 8'h00);
    tick(); chk("w1c_irq", {7'b0, irq}, 8'h00);
    wr(BASE + 2, 8'hfb);
    wr(BASE + 3, 8'h04);
    tick(); tick();
    rd("lvl_set", BASE + 1, 8'h04);
    wr(BASE + 1, 8'h04);
    rd("lvl_w1c_held", BASE + 1, 8'h04);
    ints[2] = 0;
    repeat (3) tick();
    wr(BASE + 1, 8'h04);
    rd("lvl_w1c_clr", BASE + 1, 8'h00);
    ints[3] = 0;
    tick(); tick();
    wr(BASE + 1, 8'h08);
    rd("set_wins", BASE + 1, 8'h08);
    wr(BASE, 8'h08);
    tick(); chk("ie_on_irq", {7'b0, irq}, 8'h01);
    wr(BASE, 8'h00);
    tick(); chk("ie_off_irq", {7'b0, irq}, 8'h00);
    rd("ie_off_ip_kept", BASE + 1, 8'h08);
    wr(BASE, 8'h08);
    tick(); chk("ie_reon_irq", {7'b0, irq}, 8'h01);
    wr(BASE + 4, 8'hff);
    rd("bank1_ie_mask", BASE + 4, 8'h0f);
    rd("past_end", BASE + 8, 8'h00);
    rd("below_base", BASE - 1, 8'h00);
    wr(BASE + 2, 8'h00);
    wr(BASE + 3, 8'h00);
    ints = 12'hf00;
    repeat (3) tick();
    rd("all_pend", BASE + 1, 8'hff);
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      ints = ints ^ N'($urandom);
      if (i == 2) ints = '1;
      tick();
      rd("rst_mid_ip", BASE + 1, 8'h00);
      chk("rst_mid_irq", {7'b0, irq}, 8'h00);
    end
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      rd("post_rst_ip0", BASE + 1, 8'h00);
      rd("post_rst_ip1", BASE + 5, 8'h00);
      chk("post_rst_irq", {7'b0, irq}, 8'h00);
    end
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) ints = ints ^ N'($urandom);
      csr_we = $urandom_range(2) == 0;
      csr_a = csr_we ? BASE + 5'($urandom_range(7)) : 5'($urandom);
      csr_di = 8'($urandom);
      #1;
      chk("rand_do", csr_do, rd_m(csr_a));
      chk("rand_irq", {7'b0, irq}, {7'b0, irq_m});
      tick();
    end
    csr_we = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
